// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus between the instruction fetch controller, the pipeline
// front end (PC register, decode) and the instruction memory.
//
// Handshake semantics:
//   memory request : a request transfers on a rising edge where
//                    mem_req_o=1 and mem_ready_i=1; mem_addr_o is meaningful
//                    only while mem_req_o=1.
//   memory response: mem_data_i is taken on a rising edge where
//                    mem_valid_i=1 while a request is outstanding; it is
//                    ignored at every other time.
//   decode delivery: inst_o/inst_pc_o are meaningful while inst_valid_o=1;
//                    decode consumes the instruction on an edge where
//                    stall_i=0, and flush_i=1 discards it.
interface instr_fetch_ctrl_if;
    logic        start_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        mem_ready_i;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        pc_write_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        err_o;

    // Fetch controller side
    modport slave (
        input  start_i, pc_i, stall_i, flush_i,
        input  mem_ready_i, mem_valid_i, mem_data_i,
        output mem_req_o, mem_addr_o, pc_write_o,
        output inst_o, inst_pc_o, inst_valid_o, err_o
    );

    // Pipeline / memory environment side
    modport master (
        output start_i, pc_i, stall_i, flush_i,
        output mem_ready_i, mem_valid_i, mem_data_i,
        input  mem_req_o, mem_addr_o, pc_write_o,
        input  inst_o, inst_pc_o, inst_valid_o, err_o
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one memory request per instruction,
// waits (bounded by MAX_WAIT) for the response, holds the instruction for
// decode and tells the PC register when to advance (pc_write_o, active-low).
module instr_fetch_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_fetch_ctrl_if.slave  bus,
    output logic [1:0]         state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Last WAIT count value: the MAX_WAIT-th WAIT cycle without data times out.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        drop_q, drop_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        err_q, err_d;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        pc_write;

    // Next-state and output decode; flush_i is checked before stall_i everywhere.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        err_d      = err_q;
        mem_req    = 1'b0;
        mem_addr   = '0;
        pc_write   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                mem_addr = bus.pc_i;
                if (bus.flush_i) begin
                    // Branch target loads into the PC; re-issue next cycle.
                    pc_write = 1'b0;
                end else begin
                    mem_req = 1'b1;
                    if (bus.mem_ready_i) begin
                        addr_d     = bus.pc_i;
                        wait_cnt_d = '0;
                        drop_d     = 1'b0;
                        state_d    = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (bus.flush_i) begin
                    pc_write = 1'b0;
                end
                if (bus.mem_valid_i) begin
                    if (drop_q || bus.flush_i) begin
                        // Response belongs to the squashed path.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = bus.mem_data_i;
                        inst_pc_d = addr_q;
                        state_d   = S_HOLD;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (bus.flush_i) begin
                        drop_d = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (bus.flush_i || !bus.stall_i) begin
                    // Instruction consumed or squashed: PC advances once.
                    pc_write = 1'b0;
                    state_d  = bus.start_i ? S_REQ : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            drop_q     <= 1'b0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            err_q      <= err_d;
        end
    end

    assign bus.mem_req_o    = mem_req;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.pc_write_o   = pc_write;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;
    assign bus.inst_valid_o = (state_q == S_HOLD);
    assign bus.err_o        = err_q;
    assign state_dbg_o      = state_q;

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum WAIT-state cycles before timeout, range 1..255.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  fetch enable; 1 = run, 0 = stop at next instruction boundary.
REQ-005 pc_i  input  32  current PC register value (byte address).
REQ-006 stall_i  input  1  decode-stage hazard; 1 = hold delivered instruction.
REQ-007 flush_i  input  1  branch taken; discard in-flight or delivered instruction.
REQ-008 mem_ready_i  input  1  instruction memory accepts request this cycle.
REQ-009 mem_valid_i  input  1  instruction memory returns data this cycle.
REQ-010 mem_data_i  input  32  returned instruction word.
REQ-011 mem_req_o  output  1  request valid to instruction memory.
REQ-012 mem_addr_o  output  32  request address.
REQ-013 pc_write_o  output  1  PC update control, active-low: 0 = PC loads next value at next edge, 1 = PC holds.
REQ-014 inst_o  output  32  delivered instruction.
REQ-015 inst_pc_o  output  32  address of inst_o.
REQ-016 inst_valid_o  output  1  inst_o/inst_pc_o valid for decode.
REQ-017 err_o  output  1  sticky fetch-timeout flag.

Function
REQ-018 States: IDLE, REQ, WAIT, HOLD; encoding free; no other reachable states.
REQ-019 IDLE: outputs inactive, pc_write_o=1; start_i=1 -> REQ next cycle, else stay.
REQ-020 REQ: mem_req_o=1, mem_addr_o=pc_i (combinational); mem_req_o&mem_ready_i -> latch pc_i into addr register, WAIT.
REQ-021 REQ with flush_i=1: mem_req_o=0, pc_write_o=0 for that cycle, stay REQ.
REQ-022 WAIT: mem_valid_i=1 and no pending drop -> latch mem_data_i into inst_o, addr register into inst_pc_o, go HOLD; inst_valid_o=1 from next cycle.
REQ-023 WAIT with flush_i=1: set drop flag, pc_write_o=0 that cycle; response arriving with drop set (incl. same cycle) is discarded, flag cleared, go REQ.
REQ-024 WAIT counter increments per cycle in WAIT, clears on WAIT entry; reaching MAX_WAIT without mem_valid_i -> err_o=1, go IDLE, drop flag cleared.
REQ-025 HOLD: inst_valid_o=1; pc_write_o = ~(~stall_i | flush_i) i.e. 0 when stall_i=0 or flush_i=1.
REQ-026 HOLD with stall_i=1, flush_i=0: stay HOLD, inst_o/inst_pc_o unchanged.
REQ-027 HOLD with stall_i=0 or flush_i=1: inst_valid_o=0 next cycle; start_i=1 -> REQ, start_i=0 -> IDLE.
REQ-028 flush_i has priority over stall_i in every state.
REQ-029 mem_valid_i ignored in IDLE, REQ, HOLD; mem_ready_i ignored outside REQ.
REQ-030 pc_write_o=1 in every case not listed in REQ-021/023/025; PC advances at most once per fetched instruction.
REQ-031 err_o cleared only by reset; start_i=1 after timeout restarts fetch normally.
REQ-032 Minimum throughput: 1 instruction per 3 cycles (REQ, WAIT with zero-latency valid, HOLD).

Reset
REQ-033 rst_i=0 asynchronously forces IDLE, drop flag=0, counter=0, mem_req_o=0, mem_addr_o=0, pc_write_o=1, inst_o=0, inst_pc_o=0, inst_valid_o=0, err_o=0.
REQ-034 Reset mid-transaction abandons it; late mem_valid_i after reset release ignored (state IDLE/REQ).
REQ-035 Exit from reset on rising rst_i; first transition no earlier than next clk_i edge.

Verification
REQ-036 start_i=1, pc_i=0x00000000, ready immediate, valid 1 cycle later data 0x8C010004 -> inst_o=0x8C010004, inst_pc_o=0, inst_valid_o=1, pc_write_o=0 one cycle.
REQ-037 HOLD with stall_i=1 for 3 cycles -> inst_valid_o stays 1, pc_write_o=1, no mem_req_o; stall_i=0 -> pc_write_o=0 one cycle, then REQ with new pc_i=0x4.
REQ-038 flush_i=1 in WAIT, pc_i=0x10, valid arrives next cycle with 0xDEADBEEF -> data discarded, inst_valid_o stays 0, next REQ issues mem_addr_o=branch target on pc_i.
REQ-039 MAX_WAIT=15, no mem_valid_i -> err_o=1 after 15 WAIT cycles, state IDLE, err_o persists until rst_i=0.
REQ-040 rst_i=0 asserted in WAIT between clock edges -> all outputs at reset values immediately; later mem_valid_i=1 produces no inst_valid_o.
REQ-041 start_i=0 while in HOLD, stall_i=0 -> pc_write_o=0 one cycle, then IDLE with mem_req_o=0.
